// File: rtl/dsp_mac_arbiter.sv
// Round-robin arbiter that time-shares one DSP48A1 MAC slice among NREQ requesters.
// Sequences opmode (clear/accumulate/hold) and returns each burst's 48-bit sum tagged with its requester ID.
module dsp_mac_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int MAC_LAT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_last,
  input  logic [NREQ*18-1:0]   req_a,
  input  logic [NREQ*18-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [17:0]          mac_a,
  output logic [17:0]          mac_b,
  output logic [7:0]           mac_opmode,
  input  logic [47:0]          mac_p,
  output logic                 res_valid,
  output logic [IDW-1:0]       res_id,
  output logic [47:0]          res_data
);

  localparam logic [7:0] OP_IDLE  = 8'h00;
  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [7:0] OP_ACC   = 8'h09;
  localparam logic [7:0] OP_HOLD  = 8'h08;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                      state_reg;
  logic [IDW-1:0]              grant_reg;
  logic [IDW-1:0]              rr_ptr_reg;
  logic                        first_reg;
  logic [7:0]                  op_stage_reg;
  logic [MAC_LAT:0]            trk_valid_reg;
  logic [MAC_LAT:0][IDW-1:0]   trk_id_reg;

  logic [17:0]                 a_arr [NREQ];
  logic [17:0]                 b_arr [NREQ];
  logic [17:0]                 sel_a;
  logic [17:0]                 sel_b;
  logic                        beat_acc;
  logic                        beat_last;
  logic                        pick_found;
  logic [IDW-1:0]              pick_idx;
  logic [IDW-1:0]              cand;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign a_arr[gi]     = req_a[18*gi +: 18];
      assign b_arr[gi]     = req_b[18*gi +: 18];
      assign req_ready[gi] = (state_reg == BURST) && (grant_reg == IDW'(gi));
    end
  endgenerate

  assign sel_a     = a_arr[grant_reg];
  assign sel_b     = b_arr[grant_reg];
  assign beat_acc  = (state_reg == BURST) && req_valid[grant_reg];
  assign beat_last = beat_acc && req_last[grant_reg];

  // Search starts one past the last served requester so nobody is served twice while another waits.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(rr_ptr_reg) + k) % NREQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Opmode is staged one cycle behind the operands to line up with the DSP M register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      rr_ptr_reg   <= IDW'(NREQ - 1);
      first_reg    <= 1'b0;
      mac_a        <= '0;
      mac_b        <= '0;
      op_stage_reg <= OP_IDLE;
      mac_opmode   <= OP_IDLE;
    end else begin
      mac_opmode <= op_stage_reg;
      case (state_reg)
        IDLE: begin
          mac_a        <= '0;
          mac_b        <= '0;
          op_stage_reg <= OP_IDLE;
          if (pick_found) begin
            grant_reg <= pick_idx;
            first_reg <= 1'b1;
            state_reg <= BURST;
          end
        end
        BURST: begin
          if (beat_acc) begin
            mac_a        <= sel_a;
            mac_b        <= sel_b;
            op_stage_reg <= first_reg ? OP_CLEAR : OP_ACC;
            first_reg    <= 1'b0;
            if (req_last[grant_reg]) begin
              rr_ptr_reg <= grant_reg;
              state_reg  <= IDLE;
            end
          end else begin
            mac_a        <= '0;
            mac_b        <= '0;
            op_stage_reg <= OP_HOLD;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Tracker's last stage coincides with the final sum on mac_p; it is captured on the next edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trk_valid_reg <= '0;
      trk_id_reg    <= '0;
      res_valid     <= 1'b0;
      res_id        <= '0;
      res_data      <= '0;
    end else begin
      trk_valid_reg <= {trk_valid_reg[MAC_LAT-1:0], beat_last};
      trk_id_reg    <= {trk_id_reg[MAC_LAT-1:0], grant_reg};
      res_valid     <= trk_valid_reg[MAC_LAT];
      if (trk_valid_reg[MAC_LAT]) begin
        res_id   <= trk_id_reg[MAC_LAT];
        res_data <= mac_p;
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_arbiter.sv
// Testbench for dsp_mac_arbiter: DSP48A1 pipeline model plus a burst-level reference model,
// directed test-plan cases followed by randomized bursts.
module tb_dsp_mac_arbiter;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int MAC_LAT = 3;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_last = '0;
  logic [NREQ*18-1:0]   req_a = '0;
  logic [NREQ*18-1:0]   req_b = '0;
  logic [NREQ-1:0]      req_ready;
  logic [17:0]          mac_a;
  logic [17:0]          mac_b;
  logic [7:0]           mac_opmode;
  logic [47:0]          mac_p;
  logic                 res_valid;
  logic [IDW-1:0]       res_id;
  logic [47:0]          res_data;

  always #5 clk = ~clk;

  dsp_mac_arbiter #(.NREQ(NREQ), .IDW(IDW), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_last(req_last), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .mac_a(mac_a), .mac_b(mac_b), .mac_opmode(mac_opmode), .mac_p(mac_p),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data)
  );

  // DSP48A1 with A1REG=B1REG=MREG=PREG=OPMODEREG=1
  logic signed [17:0] a1_r = '0;
  logic signed [17:0] b1_r = '0;
  logic signed [47:0] m_r = '0;
  logic [7:0]         op_r = '0;
  logic [47:0]        p_r = '0;
  assign mac_p = p_r;
  always @(posedge clk) begin
    a1_r <= mac_a;
    b1_r <= mac_b;
    m_r  <= 48'(a1_r) * 48'(b1_r);
    op_r <= mac_opmode;
    p_r  <= ((op_r[1:0] == 2'b01) ? m_r : 48'd0) + ((op_r[3:2] == 2'b10) ? p_r : 48'd0);
  end

  int n_total = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [17:0] a;
    logic [17:0] b;
    logic        last;
    int          gap;
  } beat_t;

  typedef struct {
    int          id;
    logic [47:0] data;
    int          cyc;
  } res_t;

  beat_t           beat_q [NREQ][$];
  int              gap_cnt [NREQ];
  logic [NREQ-1:0] acc_flag = '0;

  // Reference model state (burst level)
  bit              m_idle = 1'b1;
  int              m_grant = 0;
  int              m_rr = NREQ - 1;
  bit              m_first = 1'b0;
  logic [47:0]     m_sum [NREQ];
  logic [7:0]      op_h1 = '0, op_h2 = '0;
  logic [17:0]     a_h1 = '0, b_h1 = '0;
  logic [47:0]     held_data = '0;
  logic [IDW-1:0]  held_id = '0;
  int              cyc = 0;
  res_t            exp_q [$];
  res_t            obs_q [$];

  always @(negedge clk) begin
    logic [7:0]         op_c;
    logic [17:0]        a_c, b_c;
    logic [NREQ-1:0]    onehot;
    logic signed [17:0] sa, sb;
    longint             prod;
    res_t               e;
    res_t               o;
    bit                 found;
    int                 g;
    cyc++;
    if (!reset) begin
      chk_eq("rst_ctl", 64'({req_ready, mac_opmode, res_valid, res_id}), 64'd0);
      chk_eq("rst_opnd", 64'({mac_a, mac_b}), 64'd0);
      chk_eq("rst_res", 64'(res_data), 64'd0);
      m_idle = 1'b1; m_rr = NREQ - 1; m_first = 1'b0;
      op_h1 = '0; op_h2 = '0; a_h1 = '0; b_h1 = '0;
      held_data = '0; held_id = '0;
      exp_q.delete();
      acc_flag = '0;
    end else begin
      op_c = 8'h00; a_c = '0; b_c = '0;
      acc_flag = req_valid & req_ready;
      chk_eq("opmode", 64'(mac_opmode), 64'(op_h2));
      chk_eq("mac_a", 64'(mac_a), 64'(a_h1));
      chk_eq("mac_b", 64'(mac_b), 64'(b_h1));
      if (m_idle) begin
        chk_eq("ready_idle", 64'(req_ready), 64'd0);
        found = 1'b0; g = 0;
        for (int k = 1; k <= NREQ; k++)
          if (!found && req_valid[(m_rr + k) % NREQ]) begin
            found = 1'b1; g = (m_rr + k) % NREQ;
          end
        if (found) begin
          m_grant = g; m_idle = 1'b0; m_first = 1'b1;
        end
      end else begin
        onehot = '0; onehot[m_grant] = 1'b1;
        chk_eq("ready", 64'(req_ready), 64'(onehot));
        if (req_valid[m_grant]) begin
          sa = req_a[18*m_grant +: 18];
          sb = req_b[18*m_grant +: 18];
          prod = longint'(sa) * longint'(sb);
          m_sum[m_grant] = m_first ? 48'(prod) : m_sum[m_grant] + 48'(prod);
          op_c = m_first ? 8'h01 : 8'h09;
          m_first = 1'b0;
          a_c = sa; b_c = sb;
          if (req_last[m_grant]) begin
            e.id = m_grant; e.data = m_sum[m_grant]; e.cyc = cyc;
            exp_q.push_back(e);
            m_rr = m_grant; m_idle = 1'b1;
          end
        end else begin
          op_c = 8'h08;
        end
      end
      if (res_valid) begin
        o.id = int'(res_id); o.data = res_data; o.cyc = cyc;
        obs_q.push_back(o);
        $display("res id=%0d data=%012h cyc=%0d", res_id, res_data, cyc);
        if (exp_q.size() == 0) begin
          chk_eq("res_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk_eq("res_id", 64'(res_id), 64'(e.id));
          chk_eq("res_data", 64'(res_data), 64'(e.data));
          // strobe rises on the (MAC_LAT+1)th edge after the accepting edge
          chk_eq("res_lat", 64'(cyc - e.cyc), 64'(MAC_LAT + 2));
          held_data = e.data; held_id = IDW'(e.id);
        end
      end else begin
        chk_eq("res_hold", 64'({res_id, res_data}), 64'({held_id, held_data}));
      end
      op_h2 = op_h1; op_h1 = op_c; a_h1 = a_c; b_h1 = b_c;
    end
  end

  task automatic present();
    for (int i = 0; i < NREQ; i++) begin
      if (beat_q[i].size() > 0 && gap_cnt[i] == 0) begin
        req_valid[i]      = 1'b1;
        req_last[i]       = beat_q[i][0].last;
        req_a[18*i +: 18] = beat_q[i][0].a;
        req_b[18*i +: 18] = beat_q[i][0].b;
      end else begin
        req_valid[i]      = 1'b0;
        req_last[i]       = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_flag[i] && beat_q[i].size() > 0) begin
        void'(beat_q[i].pop_front());
        gap_cnt[i] = (beat_q[i].size() > 0) ? beat_q[i][0].gap : 0;
      end else if (gap_cnt[i] > 0) begin
        gap_cnt[i]--;
      end
    end
    present();
  endtask

  task automatic push_beat(input int id, input logic [17:0] a, input logic [17:0] b,
                           input logic last, input int gap);
    beat_t bt;
    bt.a = a; bt.b = b; bt.last = last; bt.gap = gap;
    beat_q[id].push_back(bt);
  endtask

  task automatic wait_done(input int bound);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      step();
      done = 1'b1;
      for (int r = 0; r < NREQ; r++)
        if (beat_q[r].size() != 0) done = 1'b0;
      if (exp_q.size() != 0 || !m_idle) done = 1'b0;
    end
    if (!done) chk_eq("timeout", 64'd0, 64'd1);
    step(); step();
  endtask

  task automatic chk_obs(input string tag, input int idx, input int id, input logic [47:0] data);
    if (idx < obs_q.size()) begin
      chk_eq({tag, "_id"}, 64'(obs_q[idx].id), 64'(id));
      chk_eq({tag, "_data"}, 64'(obs_q[idx].data), 64'(data));
    end else begin
      chk_eq({tag, "_missing"}, 64'(obs_q.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) gap_cnt[i] = 0;
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;

    // Reset mid-burst of requester 1, asserted between edges
    for (int k = 0; k < 4; k++) push_beat(1, 18'(k + 1), 18'd3, k == 3, 0);
    present();
    repeat (3) step();
    #2 reset = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      beat_q[i].delete(); gap_cnt[i] = 0;
    end
    present();
    repeat (2) step();
    reset = 1'b1;
    repeat (6) step();
    chk_eq("abort_no_res", 64'(obs_q.size()), 64'd0);

    // Requester 0 three-beat burst competing with requester 1; 0 wins after reset
    obs_q.delete();
    push_beat(0, 18'h10000, 18'h00100, 1'b0, 0);
    push_beat(0, 18'h08000, 18'h00200, 1'b0, 0);
    push_beat(0, 18'h3FFFF, 18'h00001, 1'b1, 0);
    push_beat(1, 18'd5, 18'd5, 1'b1, 0);
    present();
    wait_done(200);
    chk_obs("three_beat", 0, 0, 48'h000001FFFFFF);
    chk_obs("after_r0", 1, 1, 48'd25);

    // Stall of two cycles inside a burst of requester 2
    obs_q.delete();
    push_beat(2, 18'd3, 18'd4, 1'b0, 0);
    push_beat(2, 18'd5, 18'd6, 1'b1, 2);
    present();
    wait_done(200);
    chk_obs("stall", 0, 2, 48'd42);

    // Negative operands on requester 3
    obs_q.delete();
    push_beat(3, 18'h3FFFF, 18'h3FFFF, 1'b0, 0);
    push_beat(3, 18'h3FFFE, 18'd3, 1'b1, 0);
    present();
    wait_done(200);
    chk_obs("negative", 0, 3, 48'hFFFFFFFFFFFB);

    // All four at once, single beats
    obs_q.delete();
    for (int i = 0; i < NREQ; i++) push_beat(i, 18'(i + 1), 18'd2, 1'b1, 0);
    present();
    wait_done(200);
    for (int i = 0; i < NREQ; i++) chk_obs("all4", i, i, 48'(2 * (i + 1)));

    // Back-to-back single beats: requester 0 then requester 1
    obs_q.delete();
    push_beat(0, 18'd7, 18'd7, 1'b1, 0);
    present();
    step();
    push_beat(1, 18'd2, 18'd2, 1'b1, 0);
    present();
    wait_done(200);
    chk_obs("b2b0", 0, 0, 48'd49);
    chk_obs("b2b1", 1, 1, 48'd4);
    if (obs_q.size() >= 2) chk_eq("b2b_gap", 64'(obs_q[1].cyc - obs_q[0].cyc), 64'd2);

    // Randomized bursts across all requesters
    for (int n = 0; n < 40; n++) begin
      int id, len;
      id  = $urandom_range(0, NREQ - 1);
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++)
        push_beat(id, 18'($urandom()), 18'($urandom()), k == len - 1,
                  (k == 0) ? 0 : $urandom_range(0, 2));
    end
    present();
    wait_done(3000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
